// File: rtl/trng_health_mon_pkg.sv
// Shared constants for the TRNG health monitor: state encoding and default test limits.
// The defaults are also consumed by firmware header generation.
package trng_health_mon_pkg;

  localparam logic [1:0] ST_STARTUP = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_FAIL    = 2'd2;

  typedef enum logic [1:0] {
    STARTUP = ST_STARTUP,
    RUN     = ST_RUN,
    FAIL    = ST_FAIL
  } state_t;

  localparam int RCT_CUTOFF_DEF   = 32;
  localparam int APT_WINDOW_DEF   = 1024;
  localparam int APT_CUTOFF_DEF   = 640;
  localparam int STARTUP_BITS_DEF = 1024;

endpackage

// File: rtl/trng_apt_window.sv
// Adaptive Proportion Test: window counter, reference bit and match counter.
// fail is combinational on the accepted sample whose updated match count hits the cutoff.
module trng_apt_window
  import trng_health_mon_pkg::*;
#(
  parameter int APT_WINDOW = APT_WINDOW_DEF,
  parameter int APT_CUTOFF = APT_CUTOFF_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic sample_en,
  input  logic sample_bit,
  output logic fail
);

  localparam int WW = $clog2(APT_WINDOW + 1);
  localparam int CW = $clog2(APT_CUTOFF + 1);

  logic [WW-1:0] win_cnt, win_nxt;
  logic [CW-1:0] apt_cnt, apt_nxt;
  logic          apt_ref, ref_nxt;

  always_comb begin
    win_nxt = win_cnt;
    apt_nxt = apt_cnt;
    ref_nxt = apt_ref;
    if (win_cnt == '0) begin
      ref_nxt = sample_bit;
      apt_nxt = CW'(1);
      win_nxt = WW'(1);
    end else begin
      win_nxt = win_cnt + WW'(1);
      if (sample_bit == apt_ref && apt_cnt != CW'(APT_CUTOFF))
        apt_nxt = apt_cnt + CW'(1);
    end
    // a full window wraps to 0 so the next sample re-latches the reference
    if (win_nxt == WW'(APT_WINDOW))
      win_nxt = '0;
  end

  assign fail = sample_en && (apt_nxt == CW'(APT_CUTOFF));

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      win_cnt <= '0;
      apt_cnt <= '0;
      apt_ref <= 1'b0;
    end else if (sample_en) begin
      win_cnt <= win_nxt;
      apt_cnt <= apt_nxt;
      apt_ref <= ref_nxt;
    end
  end

endmodule

// File: rtl/trng_health_mon.sv
// Continuous RCT/APT health monitor gating raw TRNG bits; forwards with 1-cycle latency in RUN.
// Optional macro TRNG_HEALTH_STATS_EN adds saturating failure event counters.
module trng_health_mon
  import trng_health_mon_pkg::*;
#(
  parameter int RCT_CUTOFF   = RCT_CUTOFF_DEF,
  parameter int APT_WINDOW   = APT_WINDOW_DEF,
  parameter int APT_CUTOFF   = APT_CUTOFF_DEF,
  parameter int STARTUP_BITS = STARTUP_BITS_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sample_valid,
  input  logic        sample_bit,
  input  logic        fail_clear,
  output logic        out_valid,
  output logic        out_bit,
  output logic        healthy,
  output logic        rct_fail,
  output logic        apt_fail
`ifdef TRNG_HEALTH_STATS_EN
  ,
  output logic [15:0] rct_fail_cnt,
  output logic [15:0] apt_fail_cnt
`endif
);

  localparam int RW = $clog2(RCT_CUTOFF + 1);
  localparam int SW = $clog2(STARTUP_BITS + 1);

  state_t        state, state_nxt;
  logic [RW-1:0] rct_cnt, rct_cnt_nxt;
  logic          rct_last, rct_last_nxt;
  logic [SW-1:0] st_cnt, st_cnt_inc;
  logic          accept, rct_hit, apt_hit, fail_now, start_done, fwd;

  // fail_clear wins over a coincident sample; FAIL freezes both tests
  assign accept = sample_valid && !fail_clear && (state != FAIL);

  always_comb begin
    rct_cnt_nxt  = rct_cnt;
    rct_last_nxt = rct_last;
    if (rct_cnt == '0 || sample_bit != rct_last) begin
      rct_cnt_nxt  = RW'(1);
      rct_last_nxt = sample_bit;
    end else if (rct_cnt != RW'(RCT_CUTOFF)) begin
      rct_cnt_nxt = rct_cnt + RW'(1);
    end
  end

  assign rct_hit = accept && (rct_cnt_nxt == RW'(RCT_CUTOFF));

  trng_apt_window #(
    .APT_WINDOW (APT_WINDOW),
    .APT_CUTOFF (APT_CUTOFF)
  ) u_apt (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (fail_clear),
    .sample_en  (accept),
    .sample_bit (sample_bit),
    .fail       (apt_hit)
  );

  assign fail_now   = rct_hit || apt_hit;
  assign st_cnt_inc = st_cnt + SW'(1);
  assign start_done = accept && (state == STARTUP) && !fail_now && (st_cnt_inc == SW'(STARTUP_BITS));
  assign fwd        = accept && (state == RUN) && !fail_now;

  always_comb begin
    state_nxt = state;
    if (fail_clear)
      state_nxt = STARTUP;
    else if (fail_now)
      state_nxt = FAIL;
    else if (start_done)
      state_nxt = RUN;
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      state <= STARTUP;
    else
      state <= state_nxt;
  end

  assign healthy = (state == RUN);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      rct_fail  <= 1'b0;
      apt_fail  <= 1'b0;
      rct_cnt   <= '0;
      rct_last  <= 1'b0;
      st_cnt    <= '0;
    end else begin
      out_valid <= fwd;
      out_bit   <= fwd ? sample_bit : 1'b0;
      if (fail_clear) begin
        rct_fail <= 1'b0;
        apt_fail <= 1'b0;
        rct_cnt  <= '0;
        rct_last <= 1'b0;
        st_cnt   <= '0;
      end else if (accept) begin
        rct_cnt  <= rct_cnt_nxt;
        rct_last <= rct_last_nxt;
        rct_fail <= rct_fail || rct_hit;
        apt_fail <= apt_fail || apt_hit;
        if (state == STARTUP)
          st_cnt <= st_cnt_inc;
      end
    end
  end

`ifdef TRNG_HEALTH_STATS_EN
  // lifetime event counters survive fail_clear; only reset_n zeroes them
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rct_fail_cnt <= '0;
      apt_fail_cnt <= '0;
    end else begin
      if (rct_hit && rct_fail_cnt != 16'hffff)
        rct_fail_cnt <= rct_fail_cnt + 16'd1;
      if (apt_hit && apt_fail_cnt != 16'hffff)
        apt_fail_cnt <= apt_fail_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_trng_health_mon.sv
// Randomized bench for trng_health_mon against a history-based reference model.
module tb_trng_health_mon;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic sample_valid = 1'b0;
  logic sample_bit = 1'b0;
  logic fail_clear = 1'b0;
  logic out_valid, out_bit, healthy, rct_fail, apt_fail;
`ifdef TRNG_HEALTH_STATS_EN
  logic [15:0] rct_fail_cnt, apt_fail_cnt;
`endif

  trng_health_mon dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_valid (sample_valid),
    .sample_bit   (sample_bit),
    .fail_clear   (fail_clear),
    .out_valid    (out_valid),
    .out_bit      (out_bit),
    .healthy      (healthy),
    .rct_fail     (rct_fail),
    .apt_fail     (apt_fail)
`ifdef TRNG_HEALTH_STATS_EN
    ,
    .rct_fail_cnt (rct_fail_cnt),
    .apt_fail_cnt (apt_fail_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  // reference model: 0 startup, 1 run, 2 fail
  int m_state = 0;
  int m_clean = 0;
  bit m_hist[$];
  bit m_win[$];
  bit m_rf = 0, m_af = 0, m_ov = 0, m_ob = 0;
  int m_rcnt = 0, m_acnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_clean = 0; m_hist.delete(); m_win.delete();
    m_rf = 0; m_af = 0; m_ov = 0; m_ob = 0; m_rcnt = 0; m_acnt = 0;
  endtask

  task automatic model_step(input bit v, input bit b, input bit c);
    int run;
    int match;
    bit rf, af;
    m_ov = 0;
    m_ob = 0;
    if (c) begin
      m_rf = 0; m_af = 0; m_hist.delete(); m_win.delete(); m_clean = 0; m_state = 0;
    end else if (v && m_state != 2) begin
      m_hist.push_back(b);
      if (m_hist.size() > 32) void'(m_hist.pop_front());
      run = 0;
      for (int i = m_hist.size() - 1; i >= 0 && m_hist[i] == b; i--) run++;
      rf = (run >= 32);
      m_win.push_back(b);
      match = 0;
      foreach (m_win[i]) if (m_win[i] == m_win[0]) match++;
      af = (match == 640);
      if (m_win.size() == 1024) m_win.delete();
      if (rf || af) begin
        m_rf = m_rf | rf;
        m_af = m_af | af;
        if (rf && m_rcnt < 65535) m_rcnt++;
        if (af && m_acnt < 65535) m_acnt++;
        m_state = 2;
      end else if (m_state == 1) begin
        m_ov = 1;
        m_ob = b;
      end else begin
        m_clean++;
        if (m_clean == 1024) m_state = 1;
      end
    end
  endtask

  task automatic check_all();
    chk("out_valid", out_valid, m_ov);
    chk("out_bit", out_bit, m_ob);
    chk("healthy", healthy, m_state == 1);
    chk("rct_fail", rct_fail, m_rf);
    chk("apt_fail", apt_fail, m_af);
`ifdef TRNG_HEALTH_STATS_EN
    chk("rct_fail_cnt", rct_fail_cnt, m_rcnt);
    chk("apt_fail_cnt", apt_fail_cnt, m_acnt);
`endif
  endtask

  task automatic step(input bit v, input bit b, input bit c);
    sample_valid = v;
    sample_bit   = b;
    fail_clear   = c;
    model_step(v, b, c);
    @(posedge clk);
    #1;
    check_all();
    sample_valid = 0;
    fail_clear   = 0;
  endtask

  task automatic do_reset();
    reset_n      = 0;
    sample_valid = 1'($urandom_range(1));
    sample_bit   = 1'($urandom_range(1));
    fail_clear   = 0;
    @(posedge clk);
    #1;
    model_reset();
    check_all();
    sample_valid = 0;
    reset_n      = 1;
  endtask

  // mode 0 alternating, 1 random, 2 all ones, 3 repeating 0,0,1
  task automatic feed(input int n, input int mode);
    bit b;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(3) == 0) step(0, 1'($urandom_range(1)), 0);
      case (mode)
        0: b = (i % 2) == 1;
        1: b = 1'($urandom_range(1));
        2: b = 1;
        default: b = (i % 3) == 2;
      endcase
      step(1, b, 0);
    end
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    do_reset();

    // startup on alternating data, then first forwarded bit
    feed(1024, 0);
    chk("healthy_after_startup", healthy, 1);
    step(1, 1, 0);
    chk("first_fwd_valid", out_valid, 1);
    chk("first_fwd_bit", out_bit, 1);
    feed(400, 1);

    // RCT failure in RUN
    step(1, 0, 0);
    feed(32, 2);
    chk("rct_alarm", rct_fail, 1);
    chk("rct_unhealthy", healthy, 0);
    chk("rct_32nd_not_fwd", out_valid, 0);
    feed(20, 1);

    // clear with coincident sample: that sample must not count
    step(1, 1, 1);
    chk("clear_rct", rct_fail, 0);
    feed(1023, 1);
    chk("not_yet_healthy", healthy, 0);
    feed(1, 1);
    chk("healthy_again", healthy, 1);

    // APT failure from a fresh window starting with 0
    step(0, 0, 1);
    feed(1000, 3);
    chk("apt_alarm", apt_fail, 1);
    chk("apt_no_rct", rct_fail, 0);

    // reset mid-RUN
    step(0, 0, 1);
    feed(1024, 0);
    feed(50, 1);
    chk("run_before_reset", healthy, 1);
    do_reset();
    chk("reset_healthy", healthy, 0);
    chk("reset_valid", out_valid, 0);
    feed(10, 1);

`ifdef TRNG_HEALTH_STATS_EN
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 1);
      step(1, 0, 0);
      feed(32, 2);
    end
    chk("stats_rct", rct_fail_cnt, 3);
    chk("stats_apt", apt_fail_cnt, 0);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
